// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Keeps shadow copies of the destination registers in EX and MEM, produces
// registered operand-mux selects for the instruction entering EX, detects
// load-use hazards and taken-branch flushes, and counts both events.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             branch_taken_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Operand mux encoding: regfile value, MEM/WB result, EX/MEM ALU result.
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Shadow EX slot (instruction currently in EX)
    logic             ex_valid_q, ex_valid_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;

    // Shadow MEM slot (instruction currently in MEM)
    logic             mem_valid_q, mem_valid_d;
    logic             mem_regwrite_q, mem_regwrite_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;

    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic advance;
    logic ex_fwd_ok;
    logic mem_fwd_ok;

    // Select for one operand; the EX slot holds the younger result so it wins.
    // Register 0 is hard-wired and never forwarded (gated via *_fwd_ok).
    function automatic logic [1:0] pick_sel(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic             ex_ok,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_ok,
        input logic [REG_W-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = SEL_REG;
        if (use_src) begin
            if (ex_ok && (src == ex_rd)) begin
                sel = SEL_EX;
            end else if (mem_ok && (src == mem_rd)) begin
                sel = SEL_MEM;
            end
        end
        return sel;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        if (v != {CNT_W{1'b1}}) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // Load-use hazard and flush/stall arbitration (a taken branch wins).
    always_comb begin
        hazard = ex_valid_q && ex_memread_q && (ex_rd_q != ZERO_REG) && id_valid_i &&
                 ((id_use_rs_i && (id_rs_i == ex_rd_q)) ||
                  (id_use_rt_i && (id_rt_i == ex_rd_q)));
        flush_o    = branch_taken_i;
        stall_o    = hazard && !branch_taken_i;
        advance    = !stall_o && !flush_o;
        ex_fwd_ok  = ex_valid_q && ex_regwrite_q && (ex_rd_q != ZERO_REG);
        mem_fwd_ok = mem_valid_q && mem_regwrite_q && (mem_rd_q != ZERO_REG);
    end

    // Next state: slots shift down, selects computed for the instruction entering EX.
    always_comb begin
        mem_valid_d    = ex_valid_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_rd_d       = ex_rd_q;

        ex_valid_d     = 1'b0;
        ex_regwrite_d  = 1'b0;
        ex_memread_d   = 1'b0;
        ex_rd_d        = ZERO_REG;
        fwd_a_d        = SEL_REG;
        fwd_b_d        = SEL_REG;

        if (advance) begin
            ex_valid_d    = id_valid_i;
            ex_regwrite_d = id_regwrite_i;
            ex_memread_d  = id_memread_i;
            ex_rd_d       = id_rd_i;
            fwd_a_d = pick_sel(id_use_rs_i, id_rs_i, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);
            fwd_b_d = pick_sel(id_use_rt_i, id_rt_i, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);
        end

        stall_cnt_d = stall_o ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_o ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State registers; reset clears every slot so no hazard survives it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= ZERO_REG;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= ZERO_REG;
            fwd_a_q        <= SEL_REG;
            fwd_b_q        <= SEL_REG;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= mem_valid_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_rd_q       <= mem_rd_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. Counters are built 4 bits wide so that
// saturation is reachable in a few dozen cycles.
module tb_fwd_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic             id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic             branch_taken;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (id_use_rs),
        .id_use_rt_i    (id_use_rt),
        .id_rd_i        (id_rd),
        .id_regwrite_i  (id_regwrite),
        .id_memread_i   (id_memread),
        .branch_taken_i (branch_taken),
        .fwd_a_sel_o    (fwd_a),
        .fwd_b_sel_o    (fwd_b),
        .stall_o        (stall),
        .flush_o        (flush),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in ID, then let combinational outputs settle.
    task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input int rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rd       = REG_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic idle(input int n);
        branch_taken = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        if (fwd_a !== 2'b00) begin $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b00) begin $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); errors++; end
        checks++;
        if (stall !== 1'b0) begin $display("FAIL reset_stall: got %0d want 0", stall); errors++; end
        checks++;
        if (flush !== 1'b0) begin $display("FAIL reset_flush: got %0d want 0", flush); errors++; end
        checks++;
        if (stall_cnt !== 4'd0) begin $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); errors++; end
        checks++;
        if (flush_cnt !== 4'd0) begin $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); errors++; end
        checks++;
    endtask

    // add $3,$1,$2 ; add $4,$3,$3
    task automatic test_back_to_back();
        idle(2);
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        if (stall !== 1'b0) begin $display("FAIL b2b_stall: got %0d want 0", stall); errors++; end
        checks++;
        tick();
        if (fwd_a !== 2'b10) begin $display("FAIL b2b_fwd_a: got %0d want 2", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b10) begin $display("FAIL b2b_fwd_b: got %0d want 2", fwd_b); errors++; end
        checks++;
    endtask

    // add $3 ; nop ; sub $5,$3,$1
    task automatic test_mem_forward();
        idle(2);
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3, 1, 1'b1, 1'b1, 5, 1'b1, 1'b0);
        tick();
        if (fwd_a !== 2'b01) begin $display("FAIL memfwd_fwd_a: got %0d want 1", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b00) begin $display("FAIL memfwd_fwd_b: got %0d want 0", fwd_b); errors++; end
        checks++;
    endtask

    // lw $2,0($1) ; add $6,$2,$7
    task automatic test_load_use();
        idle(2);
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 2, 7, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        if (stall !== 1'b1) begin $display("FAIL ldu_stall: got %0d want 1", stall); errors++; end
        checks++;
        if (flush !== 1'b0) begin $display("FAIL ldu_flush: got %0d want 0", flush); errors++; end
        checks++;
        tick();
        if (fwd_a !== 2'b00) begin $display("FAIL ldu_bubble_fwd_a: got %0d want 0", fwd_a); errors++; end
        checks++;
        if (stall !== 1'b0) begin $display("FAIL ldu_stall_once: got %0d want 0", stall); errors++; end
        checks++;
        if (stall_cnt !== 4'd1) begin $display("FAIL ldu_stall_cnt: got %0d want 1", stall_cnt); errors++; end
        checks++;
        tick();
        if (fwd_a !== 2'b01) begin $display("FAIL ldu_fwd_a: got %0d want 1", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b00) begin $display("FAIL ldu_fwd_b: got %0d want 0", fwd_b); errors++; end
        checks++;
    endtask

    // lw $2 in EX, consumer in ID, branch taken the same cycle
    task automatic test_branch_flush();
        idle(2);
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        tick();
        branch_taken = 1'b1;
        set_id(1'b1, 2, 2, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        if (flush !== 1'b1) begin $display("FAIL br_flush: got %0d want 1", flush); errors++; end
        checks++;
        if (stall !== 1'b0) begin $display("FAIL br_stall: got %0d want 0", stall); errors++; end
        checks++;
        tick();
        branch_taken = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        if (fwd_a !== 2'b00) begin $display("FAIL br_fwd_a: got %0d want 0", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b00) begin $display("FAIL br_fwd_b: got %0d want 0", fwd_b); errors++; end
        checks++;
        if (flush_cnt !== 4'd1) begin $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); errors++; end
        checks++;
        if (stall_cnt !== 4'd1) begin $display("FAIL br_stall_cnt: got %0d want 1", stall_cnt); errors++; end
        checks++;
    endtask

    // lw $0 ; add $0 ; consumer of $0,$0
    task automatic test_zero_reg();
        idle(2);
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        if (stall !== 1'b0) begin $display("FAIL zero_stall: got %0d want 0", stall); errors++; end
        checks++;
        tick();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 8, 1'b1, 1'b0);
        tick();
        if (fwd_a !== 2'b00) begin $display("FAIL zero_fwd_a: got %0d want 0", fwd_a); errors++; end
        checks++;
        if (fwd_b !== 2'b00) begin $display("FAIL zero_fwd_b: got %0d want 0", fwd_b); errors++; end
        checks++;
    endtask

    // add $1 ; lw $2,0($1) (sel_a=10 pending) ; consumer of $2 -> stall, then reset
    task automatic test_reset_mid_stall();
        idle(2);
        set_id(1'b1, 4, 5, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0);
        if (stall !== 1'b1) begin $display("FAIL rstmid_pre_stall: got %0d want 1", stall); errors++; end
        checks++;
        if (fwd_a !== 2'b10) begin $display("FAIL rstmid_pre_fwd_a: got %0d want 2", fwd_a); errors++; end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if (stall !== 1'b0) begin $display("FAIL rstmid_stall: got %0d want 0", stall); errors++; end
        checks++;
        if (fwd_a !== 2'b00) begin $display("FAIL rstmid_fwd_a: got %0d want 0", fwd_a); errors++; end
        checks++;
        if (stall_cnt !== 4'd0) begin $display("FAIL rstmid_stall_cnt: got %0d want 0", stall_cnt); errors++; end
        checks++;
        if (flush_cnt !== 4'd0) begin $display("FAIL rstmid_flush_cnt: got %0d want 0", flush_cnt); errors++; end
        checks++;
        tick();
        rst = 1'b0;
        idle(1);
    endtask

    // lw $2,0($2) held in ID: stalls on every other cycle; flush held high.
    task automatic test_saturate();
        idle(2);
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        if (stall_cnt !== 4'd5) begin $display("FAIL sat_stall_cnt_mid: got %0d want 5", stall_cnt); errors++; end
        checks++;
        for (int i = 0; i < 30; i++) tick();
        if (stall_cnt !== 4'hF) begin $display("FAIL sat_stall_cnt_hold: got %0d want 15", stall_cnt); errors++; end
        checks++;
        branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        if (flush_cnt !== 4'hF) begin $display("FAIL sat_flush_cnt_hold: got %0d want 15", flush_cnt); errors++; end
        checks++;
        if (stall_cnt !== 4'hF) begin $display("FAIL sat_stall_cnt_final: got %0d want 15", stall_cnt); errors++; end
        checks++;
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0;
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_mem_forward();
        test_load_use();
        test_branch_flush();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
